// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    localparam int          REG_W    = 4;
    localparam int          RA_IDX   = 15;
    localparam logic [31:0] NOP_INSN = 32'h6800_0000;

endpackage

// File: rtl/of_hazard_ctrl_if.sv
// OF-stage hazard handshake: the pipeline (master) presents the OF instruction,
// the interlock controller (slave) answers with stall/bubble/flush/issue.
interface of_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic             of_valid;
    logic [REG_W-1:0] of_rs1;
    logic [REG_W-1:0] of_rs2;
    logic             of_uses_rs1;
    logic             of_uses_rs2;
    logic             of_writes_rd;
    logic [REG_W-1:0] of_rd;
    logic             ex_branch_taken;

    logic             stall;
    logic             bubble_ex;
    logic             flush_if_of;
    logic             issue;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2,
               of_writes_rd, of_rd, ex_branch_taken,
        input  stall, bubble_ex, flush_if_of, issue, state, stall_count
    );

    modport slave (
        input  of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2,
               of_writes_rd, of_rd, ex_branch_taken,
        output stall, bubble_ex, flush_if_of, issue, state, stall_count
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown of cycles until a pending write becomes readable.
// Two combinational busy read ports, one set port, global decrement.
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = 3,
    parameter int NUM_REGS   = 16,
    parameter int CW         = $clog2(WB_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rd_addr_a,
    input  logic [REG_W-1:0] rd_addr_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr
);

    logic [CW-1:0] cnt [NUM_REGS];

    // A set on the same entry wins over its decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (set_en && set_addr == REG_W'(r))
                    cnt[r] <= CW'(WB_LATENCY);
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    assign busy_a = (cnt[rd_addr_a] != '0);
    assign busy_b = (cnt[rd_addr_b] != '0);

endmodule

// File: rtl/of_hazard_ctrl.sv
// OF-stage interlock: stalls on scoreboard RAW hazards, squashes on taken
// branches, and counts stall cycles.
//   state | meaning
//   RUN   | normal flow, OF issues when valid and hazard-free
//   STALL | previous cycle stalled on a pending source register
//   FLUSH | OF holds a squashed instruction; inject bubble, no issue
module of_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = 3,
    parameter int NUM_REGS   = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    of_hazard_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_STALL = STALL;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_count_q;
    logic             busy_rs1, busy_rs2, hazard;
    logic             stall, bubble_ex, flush_if_of, issue;

    reg_scoreboard #(
        .WB_LATENCY (WB_LATENCY),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (bus.of_rs1),
        .rd_addr_b (bus.of_rs2),
        .busy_a    (busy_rs1),
        .busy_b    (busy_rs2),
        .set_en    (issue && bus.of_writes_rd),
        .set_addr  (bus.of_rd)
    );

    assign hazard = bus.of_valid &&
                    ((bus.of_uses_rs1 && busy_rs1) || (bus.of_uses_rs2 && busy_rs2));

    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_of = 1'b0;
        issue       = 1'b0;
        state_d     = ST_RUN;
        if (reset) begin
            issue = bus.of_valid;
        end else if (bus.ex_branch_taken) begin
            flush_if_of = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            bubble_ex = 1'b1;
        end else if (hazard) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_STALL;
        end else begin
            issue = bus.of_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall && stall_count_q != '1)
                stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign bus.stall       = stall;
    assign bus.bubble_ex   = bubble_ex;
    assign bus.flush_if_of = flush_if_of;
    assign bus.issue       = issue;
    assign bus.state       = state_q;
    assign bus.stall_count = stall_count_q;

endmodule
